// File: rtl/riscv_state_dump.sv
// riscv_state_dump: streams the register file (x0..x(NREG-1)) and then the
// data memory words out over a valid/ready beat interface on a start pulse.
// Optional feature macro: DUMP_MEM_EN. When defined, the memory walk
// (MEM_REQ/MEM_CAP) is built. When undefined, the last register beat
// carries dout_last and dm_re/dm_raddr are tied to 0.
module riscv_state_dump #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DMEM_WORDS = 1024,
  parameter int DM_AW      = 10
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  output logic [4:0]       rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             dm_re,
  output logic [DM_AW-1:0] dm_raddr,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [XLEN-1:0]  dout_data,
  output logic             dout_tag,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  // idx walks both register indices (5 bits) and memory word addresses
  localparam int IW = (DM_AW > 5) ? DM_AW : 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REG,
    S_MEM_REQ,
    S_MEM_CAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          load_ok;
  logic          accept;

  assign load_ok = !dout_valid || dout_ready;
  assign accept  = dout_valid && dout_ready;

  // Read-address decode: register address only while walking the register file
  always_comb begin
    rf_raddr = '0;
    if (state == S_REG) rf_raddr = idx[4:0];
  end

`ifdef DUMP_MEM_EN
  // Memory read strobe is a pure state decode, so it lasts exactly one cycle
  always_comb begin
    dm_re    = (state == S_MEM_REQ);
    dm_raddr = idx[DM_AW-1:0];
  end
`else
  logic unused_mem;
  assign unused_mem = ^{dm_rdata, 32'(DMEM_WORDS)};

  // Memory walk not built: read port held inactive
  always_comb begin
    dm_re    = 1'b0;
    dm_raddr = '0;
  end
`endif

  // Dump sequencer with registered beat, busy and done outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_tag   <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // A handshake retires the beat; a same-cycle load below overrides this
      if (accept) dout_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_REG;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end

        S_REG: begin
          if (load_ok) begin
            dout_valid <= 1'b1;
            dout_data  <= rf_rdata;
            dout_tag   <= 1'b0;
            dout_last  <= 1'b0;
            if (idx == IW'(NREG - 1)) begin
`ifdef DUMP_MEM_EN
              state <= S_MEM_REQ;
              idx   <= '0;
`else
              dout_last <= 1'b1;
              state     <= S_DRAIN;
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

`ifdef DUMP_MEM_EN
        S_MEM_REQ: begin
          state <= S_MEM_CAP;
        end

        S_MEM_CAP: begin
          if (load_ok) begin
            dout_valid <= 1'b1;
            dout_data  <= dm_rdata;
            dout_tag   <= 1'b1;
            if (idx == IW'(DMEM_WORDS - 1)) begin
              dout_last <= 1'b1;
              state     <= S_DRAIN;
            end else begin
              dout_last <= 1'b0;
              idx       <= idx + IW'(1);
              state     <= S_MEM_REQ;
            end
          end
        end
`endif

        S_DRAIN: begin
          if (accept) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_state_dump.sv
// Bench for riscv_state_dump: scenario table of dumps checked beat-by-beat
// against an expected stream built from the register/memory contents,
// plus a hand-written reset-abort sequence.
module tb_riscv_state_dump;

  localparam int NREG = 32;
`ifdef DUMP_MEM_EN
  localparam int NMEM = 4;
`else
  localparam int NMEM = 0;
`endif

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dm_re;
  logic [1:0]  dm_raddr;
  logic [31:0] dm_rdata = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [31:0] dout_data;
  logic        dout_tag;
  logic        dout_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [NREG];
  logic [31:0] mem [4];

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_data [$];
  logic        exp_tag  [$];
  logic        exp_last [$];

  riscv_state_dump #(.XLEN(32), .NREG(NREG), .DMEM_WORDS(4), .DM_AW(2)) dut (
    .clk1(clk1), .rst(rst), .start(start),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dm_re(dm_re), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_tag(dout_tag), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk1) if (dm_re) dm_rdata <= mem[dm_raddr];

  typedef struct {
    int mode;       // 0: ready=1, 1: ready toggles 1010..., 2: random ready
    int start_mid;  // cycle at which a stray start is raised (0 = none)
    int rand_data;  // 1: randomize register/memory contents first
    int exp_beats;
    int exp_dmre;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void build_expected();
    exp_data.delete(); exp_tag.delete(); exp_last.delete();
    for (int i = 0; i < NREG; i++) begin
      exp_data.push_back(rf[i]);
      exp_tag.push_back(1'b0);
      exp_last.push_back(NMEM == 0 && i == NREG - 1);
    end
    for (int k = 0; k < NMEM; k++) begin
      exp_data.push_back(mem[k]);
      exp_tag.push_back(1'b1);
      exp_last.push_back(k == NMEM - 1);
    end
  endfunction

  function automatic int beat_time(input int b);
    return (b < NREG) ? 1 + b : NREG + 2 + 2 * (b - NREG);
  endfunction

  // Caller must be at #1 after a rising edge
  task automatic run_dump(input vec_t v);
    int nb = 0, dmre = 0, cyc = 0, last_hs = -100;
    bit seen_done = 0, stall_prev = 0;
    logic [31:0] pd = '0;
    logic pt = 1'b0, pl = 1'b0;
    build_expected();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    while (!seen_done && cyc < 400) begin
      start = (v.start_mid > 0 && cyc == v.start_mid);
      case (v.mode)
        0: dout_ready = 1'b1;
        1: dout_ready = (cyc % 2 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk1);
      if (cyc == 0) chk("busy_after_start", busy, 1);
      if (dm_re) dmre++;
      if (done) begin
        chk("done_timing", cyc, last_hs + 1);
        seen_done = 1;
      end
      if (stall_prev) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_data", dout_data, pd);
        chk("stall_tag", dout_tag, pt);
        chk("stall_last", dout_last, pl);
      end
      if (dout_valid && dout_ready) begin
        if (nb < exp_data.size()) begin
          chk($sformatf("beat%0d_data", nb), dout_data, exp_data[nb]);
          chk($sformatf("beat%0d_tag", nb), dout_tag, exp_tag[nb]);
          chk($sformatf("beat%0d_last", nb), dout_last, exp_last[nb]);
          if (v.mode == 0) chk($sformatf("beat%0d_time", nb), cyc, beat_time(nb));
        end else begin
          chk("extra_beat", nb, exp_data.size());
        end
        last_hs = cyc;
        nb++;
      end
      stall_prev = dout_valid && !dout_ready;
      pd = dout_data; pt = dout_tag; pl = dout_last;
      @(posedge clk1); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("beat_count", nb, v.exp_beats);
    chk("dm_re_count", dmre, v.exp_dmre);
    @(negedge clk1);
    chk("busy_idle", busy, 0);
    chk("valid_idle", dout_valid, 0);
    chk("done_single", done, 0);
    @(posedge clk1); #1;
  endtask

  task automatic preload_plan();
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    rf[26] = 32'habcdef12;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
  endtask

  task automatic preload_rand();
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
    for (int k = 0; k < 4; k++) mem[k] = $urandom;
    if (rf[0] == '0) rf[0] = 32'h1;
  endtask

  task automatic abort_sequence();
    int nb = 0, guard = 0, dseen = 0;
    dout_ready = 1'b1;
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    while (nb < 10 && guard < 100) begin
      @(negedge clk1);
      if (dout_valid && dout_ready) nb++;
      @(posedge clk1); #1;
      guard++;
    end
    chk("abort_reach_beat10", nb, 10);
    dout_ready = 1'b0;
    @(negedge clk1);
    chk("abort_beat10_valid", dout_valid, 1);
    chk("abort_beat10_data", dout_data, rf[10]);
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    @(negedge clk1);
    chk("abort_valid", dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", dout_data, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      if (done || dout_valid) dseen++;
    end
    chk("abort_quiet", dseen, 0);
    @(posedge clk1); #1;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 0, 0, NREG + NMEM, NMEM};
    vecs[1] = '{1, 0, 0, NREG + NMEM, NMEM};
    vecs[2] = '{0, 5, 0, NREG + NMEM, NMEM};
    vecs[3] = '{0, 0, 0, NREG + NMEM, NMEM};
    vecs[4] = '{2, 0, 1, NREG + NMEM, NMEM};
    vecs[5] = '{2, 0, 1, NREG + NMEM, NMEM};
    vecs[6] = '{1, 0, 1, NREG + NMEM, NMEM};

    preload_plan();
    rst = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    @(negedge clk1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_tag", dout_tag, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_dm_re", dm_re, 0);
    chk("rst_dm_raddr", dm_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk1); #1;
    rst = 1'b0;
    @(posedge clk1); #1;

    for (int t = 0; t < 7; t++) begin
      if (vecs[t].rand_data != 0) preload_rand();
      run_dump(vecs[t]);
    end

    preload_rand();
    abort_sequence();
    run_dump('{0, 0, 0, NREG + NMEM, NMEM});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_state_dump.md
# riscv_state_dump

Hardware state-dump engine attached to the RISC_V core. On a start pulse it walks the architectural register file (x0..x31) and then the data memory words, streaming each 32-bit word out over a valid/ready interface. It replaces hierarchical end-of-simulation peeks: its stream can feed a bench file-writer, a UART, or an on-chip checker, so the same sign-off flow works in simulation and on silicon.

## Interface
Parameters:
- `XLEN`, 32, data word width
- `NREG`, 32, registers dumped, indices 0..NREG-1
- `DMEM_WORDS`, 1024, data memory words dumped
- `DM_AW`, 10, data memory word-address width; must satisfy 2^DM_AW >= DMEM_WORDS

Ports:
- Clock and reset: one clock, `clk1`. Reset `rst` is synchronous and active-high.
- `clk1` in 1: clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: dump request, sampled in IDLE only
- `rf_raddr` out 5: register file read address
- `rf_rdata` in XLEN: combinational read data for `rf_raddr`
- `dm_re` out 1: data memory read strobe
- `dm_raddr` out DM_AW: data memory word address
- `dm_rdata` in XLEN: read data, valid one cycle after `dm_re`, held until next `dm_re`
- `dout_valid` out 1: stream beat valid
- `dout_ready` in 1: consumer accepts beat
- `dout_data` out XLEN: beat payload
- `dout_tag` out 1: 0 = register beat, 1 = memory beat
- `dout_last` out 1: final beat of dump
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, REG, MEM_REQ, MEM_CAP, DRAIN, DONE. Index counter `idx` is cleared on entering REG and on entering MEM_REQ from REG.
- The output register is loadable when `!dout_valid || dout_ready`; call this `load_ok`. A beat is accepted when `dout_valid && dout_ready`.
- IDLE: `start`=1 → REG, `idx`=0. In all other states `start` is ignored.
- REG: `rf_raddr`=idx. On `load_ok`, load `rf_rdata`, set tag=0, and increment `idx`. After loading idx NREG-1 → MEM_REQ with `idx`=0.
- MEM_REQ: `dm_re`=1 and `dm_raddr`=idx for exactly one cycle → MEM_CAP.
- MEM_CAP: wait for `load_ok`, then load `dm_rdata` with tag=1. `dout_last` = (idx==DMEM_WORDS-1). If last → DRAIN; otherwise increment `idx` → MEM_REQ.
- DRAIN: on acceptance of the last beat → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- When `dout_valid`=1 and `dout_ready`=0, `dout_data`, `dout_tag` and `dout_last` hold stable. Valid never drops without a handshake.
- x0 is emitted as read (`rf_rdata`). The block does not force it to zero.

## Timing
- Reset values: `dout_valid`=0, `dout_data`=0, `dout_tag`=0, `dout_last`=0, `rf_raddr`=0, `dm_re`=0, `dm_raddr`=0, `busy`=0, `done`=0; state IDLE, `idx`=0.
- `rst` during any state aborts the dump. The next cycle is IDLE with reset values, and no `done` is issued.
- `start` sampled at edge E. With `dout_ready` held at 1:
  - register i beat is valid after edge E+1+i.
  - memory word k beat is valid after edge E+NREG+2+2k.
  - `done` is high in the cycle after the last handshake.
- Throughput: 1 beat/cycle for registers, 1 beat/2 cycles for memory.
- Backpressure stalls REG and MEM_CAP only. `dm_re` is never reissued while stalled.
- `start` asserted in the same cycle as `done` is ignored, because the FSM is not yet in IDLE.

## Configuration
- `DUMP_MEM_EN` defined: behaviour as above.
- `DUMP_MEM_EN` undefined:
  - memory states are not built; `dm_re` and `dm_raddr` are tied to 0.
  - the register x(NREG-1) beat carries `dout_last`=1, and REG goes directly to DRAIN.
  - total dump is NREG beats.

## Test plan
- Reset, then preload x26=32'habcdef12, others 0, with `DMEM_WORDS`=4 and d_mem={11,22,33,44}. Pulse `start` with ready=1 → 36 beats. Beat 26 is abcdef12 tag 0. Beats 32..35 are 11,22,33,44 tag 1, with last only on beat 35. `done` pulses the cycle after beat 35.
- Same setup with `dout_ready` toggling 1010… → identical beat sequence. Data is stable while stalled, and `dm_re` pulses exactly 4 times.
- Assert `start` again during REG phase → ignored, and beat count stays 36. `start` in IDLE after `done` → a second identical dump.
- Assert `rst` at register beat 10 with ready=0 → next cycle `dout_valid`=0 and `busy`=0, with no `done`. A later `start` dumps from x0.
- Build without `DUMP_MEM_EN` → exactly 32 beats, last on x31 = 0, `dm_re` never asserted, and `done` one cycle after x31 is accepted.
